// File: rtl/alu_opnd_stage_pkg.sv
// Types and helpers shared by the operand stage and its forwarding lookup.
`include "rooth_defines.sv"

package alu_opnd_stage_pkg;

    localparam int REG_ADDR_W = 5;

    typedef struct packed {
        logic rs1;
        logic rs2;
    } opnd_use_t;

    // Which register sources an operand select code actually reads.
    function automatic opnd_use_t decode_use(input logic [`ALU_SRC_WIDTH-1:0] sel);
        opnd_use_t use_v;
        use_v.rs1 = 1'b0;
        use_v.rs2 = 1'b0;
        case (sel)
            `ALU_SRC_REG: begin
                use_v.rs1 = 1'b1;
                use_v.rs2 = 1'b1;
            end
            `ALU_SRC_IMM,
            `ALU_SRC_CSR_REG,
            `ALU_SRC_CSRIN_REG: use_v.rs1 = 1'b1;
            default: ;
        endcase
        return use_v;
    endfunction

endpackage

// File: rtl/alu_opnd_stage_fwd_lookup.sv
// Priority forwarding lookup: the lowest-index matching channel wins, x0 never forwards.
import alu_opnd_stage_pkg::*;

module fwd_lookup #(
    parameter int N_FWD = 3,
    parameter int XLEN  = 32
) (
    input  logic [REG_ADDR_W-1:0]       addr_i,
    input  logic [XLEN-1:0]             reg_data_i,
    input  logic [N_FWD-1:0]            fwd_valid_i,
    input  logic [REG_ADDR_W*N_FWD-1:0] fwd_addr_i,
    input  logic [XLEN*N_FWD-1:0]       fwd_data_i,
    input  logic [N_FWD-1:0]            fwd_pend_i,
    output logic [XLEN-1:0]             data_o,
    output logic                        hit_o,
    output logic                        pend_o
);

    // Scan from the oldest channel down so younger matches overwrite older ones.
    always_comb begin
        data_o = reg_data_i;
        hit_o  = 1'b0;
        pend_o = 1'b0;
        for (int i = N_FWD - 1; i >= 0; i--) begin
            if ((addr_i != '0) && fwd_valid_i[i] &&
                (fwd_addr_i[REG_ADDR_W*i +: REG_ADDR_W] == addr_i)) begin
                data_o = fwd_data_i[XLEN*i +: XLEN];
                hit_o  = 1'b1;
                pend_o = fwd_pend_i[i];
            end
        end
    end

endmodule

// File: rtl/rooth_defines.sv
// Shared core-wide widths and ALU operand select codes.
`ifndef ROOTH_DEFINES_SV
`define ROOTH_DEFINES_SV

`define CPU_WIDTH         32
`define ALU_SRC_WIDTH     3

`define ALU_SRC_REG       3'd0
`define ALU_SRC_IMM       3'd1
`define ALU_SRC_FOUR_PC   3'd2
`define ALU_SRC_IMM_PC    3'd3
`define ALU_SRC_CSR_REG   3'd4
`define ALU_SRC_CSRIN_REG 3'd5
`define ALU_SRC_CSR_IMM   3'd6

`endif

// File: rtl/alu_opnd_stage.sv
// ALU operand stage: forwards, selects and registers the operand pair behind a valid/ready handshake.
`include "rooth_defines.sv"

module alu_opnd_stage
    import alu_opnd_stage_pkg::*;
#(
    parameter int XLEN  = `CPU_WIDTH,
    parameter int N_FWD = 3,
    parameter int CNT_W = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        flush_i,
    input  logic                        in_valid_i,
    output logic                        in_ready_o,
    input  logic [`ALU_SRC_WIDTH-1:0]   alu_src_sel_i,
    input  logic [REG_ADDR_W-1:0]       rs1_addr_i,
    input  logic [REG_ADDR_W-1:0]       rs2_addr_i,
    input  logic [XLEN-1:0]             reg1_rd_data_i,
    input  logic [XLEN-1:0]             reg2_rd_data_i,
    input  logic [XLEN-1:0]             csr_rd_data_i,
    input  logic [XLEN-1:0]             imm_i,
    input  logic [XLEN-1:0]             curr_pc_i,
    input  logic [N_FWD-1:0]            fwd_valid_i,
    input  logic [REG_ADDR_W*N_FWD-1:0] fwd_addr_i,
    input  logic [XLEN*N_FWD-1:0]       fwd_data_i,
    input  logic [N_FWD-1:0]            fwd_pend_i,
    output logic                        out_valid_o,
    input  logic                        out_ready_i,
    output logic [XLEN-1:0]             alu_src1_o,
    output logic [XLEN-1:0]             alu_src2_o,
    output logic                        hazard_stall_o,
    output logic [CNT_W-1:0]            stall_cnt_o
);

    logic [XLEN-1:0]  r1, r2;
    logic             r1_hit, r2_hit;
    logic             r1_pend, r2_pend;
    opnd_use_t        opnd_use;
    logic             hazard;
    logic             accept;

    logic [XLEN-1:0]  opnd1, opnd2;

    logic             out_valid_d,  out_valid_q;
    logic [XLEN-1:0]  alu_src1_d,   alu_src1_q;
    logic [XLEN-1:0]  alu_src2_d,   alu_src2_q;
    logic [CNT_W-1:0] stall_cnt_d,  stall_cnt_q;

    fwd_lookup #(
        .N_FWD (N_FWD),
        .XLEN  (XLEN)
    ) u_fwd_rs1 (
        .addr_i      (rs1_addr_i),
        .reg_data_i  (reg1_rd_data_i),
        .fwd_valid_i (fwd_valid_i),
        .fwd_addr_i  (fwd_addr_i),
        .fwd_data_i  (fwd_data_i),
        .fwd_pend_i  (fwd_pend_i),
        .data_o      (r1),
        .hit_o       (r1_hit),
        .pend_o      (r1_pend)
    );

    fwd_lookup #(
        .N_FWD (N_FWD),
        .XLEN  (XLEN)
    ) u_fwd_rs2 (
        .addr_i      (rs2_addr_i),
        .reg_data_i  (reg2_rd_data_i),
        .fwd_valid_i (fwd_valid_i),
        .fwd_addr_i  (fwd_addr_i),
        .fwd_data_i  (fwd_data_i),
        .fwd_pend_i  (fwd_pend_i),
        .data_o      (r2),
        .hit_o       (r2_hit),
        .pend_o      (r2_pend)
    );

    // Only a source the selected operation reads can stall it; pend is already
    // restricted to the winning channel, so older pending producers are ignored.
    always_comb begin
        opnd_use = decode_use(alu_src_sel_i);
        hazard   = in_valid_i &&
                   ((opnd_use.rs1 && r1_hit && r1_pend) ||
                    (opnd_use.rs2 && r2_hit && r2_pend));
        in_ready_o = (!out_valid_q || out_ready_i) && !hazard && !flush_i;
        accept     = in_valid_i && in_ready_o;
    end

    always_comb begin
        opnd1 = r1;
        opnd2 = r2;
        case (alu_src_sel_i)
            `ALU_SRC_REG: begin
                opnd1 = r1;
                opnd2 = r2;
            end
            `ALU_SRC_IMM: begin
                opnd1 = r1;
                opnd2 = imm_i;
            end
            `ALU_SRC_FOUR_PC: begin
                opnd1 = XLEN'(4);
                opnd2 = curr_pc_i;
            end
            `ALU_SRC_IMM_PC: begin
                opnd1 = curr_pc_i;
                opnd2 = imm_i;
            end
            `ALU_SRC_CSR_REG: begin
                opnd1 = r1;
                opnd2 = csr_rd_data_i;
            end
            `ALU_SRC_CSRIN_REG: begin
                opnd1 = ~r1;
                opnd2 = csr_rd_data_i;
            end
            `ALU_SRC_CSR_IMM: begin
                opnd1 = csr_rd_data_i;
                opnd2 = imm_i;
            end
            default: begin
                opnd1 = r1;
                opnd2 = r2;
            end
        endcase
    end

    // Flush only drops the valid bit; operand registers keep their last contents.
    always_comb begin
        out_valid_d = out_valid_q;
        alu_src1_d  = alu_src1_q;
        alu_src2_d  = alu_src2_q;
        if (flush_i) begin
            out_valid_d = 1'b0;
        end else if (accept) begin
            out_valid_d = 1'b1;
            alu_src1_d  = opnd1;
            alu_src2_d  = opnd2;
        end else if (out_ready_i) begin
            out_valid_d = 1'b0;
        end
    end

    always_comb begin
        stall_cnt_d = '0;
        if (hazard && !flush_i) begin
            if (stall_cnt_q == {CNT_W{1'b1}}) begin
                stall_cnt_d = stall_cnt_q;
            end else begin
                stall_cnt_d = stall_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            alu_src1_q  <= '0;
            alu_src2_q  <= '0;
            stall_cnt_q <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            alu_src1_q  <= alu_src1_d;
            alu_src2_q  <= alu_src2_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign out_valid_o    = out_valid_q;
    assign alu_src1_o     = alu_src1_q;
    assign alu_src2_o     = alu_src2_q;
    assign hazard_stall_o = hazard;
    assign stall_cnt_o    = stall_cnt_q;

endmodule

// File: doc/alu_opnd_stage.md
ALU_OPND_STAGE -- requirements
Module: alu_opnd_stage

Interface
REQ-001 Parameters SHALL be one per line: name, default, meaning.
- XLEN, 32, operand width.
- N_FWD, 3, forwarding channels; index 0 is the youngest producer.
- CNT_W, 4, stall counter width.
REQ-002 Ports SHALL be one per line: name, direction, width, meaning.
- clk, in, 1, sole clock.
- rst, in, 1, asynchronous, active-high reset.
- flush_i, in, 1, discard the held operand pair.
- in_valid_i, in, 1, decode offers an operation.
- in_ready_o, out, 1, stage accepts the operation.
- alu_src_sel_i, in, `ALU_SRC_WIDTH, operand select code.
- rs1_addr_i, in, 5, source register 1 index.
- rs2_addr_i, in, 5, source register 2 index.
- reg1_rd_data_i, in, XLEN, register file port 1 data.
- reg2_rd_data_i, in, XLEN, register file port 2 data.
- csr_rd_data_i, in, XLEN, CSR read data.
- imm_i, in, XLEN, immediate.
- curr_pc_i, in, XLEN, instruction PC.
- fwd_valid_i, in, N_FWD, channel carries a register write.
- fwd_addr_i, in, 5*N_FWD, channel destination index.
- fwd_data_i, in, XLEN*N_FWD, channel result.
- fwd_pend_i, in, N_FWD, channel result not yet available (load in flight).
- out_valid_o, out, 1, held operand pair is valid.
- out_ready_i, in, 1, ALU consumes the pair.
- alu_src1_o, out, XLEN, registered operand 1.
- alu_src2_o, out, XLEN, registered operand 2.
- hazard_stall_o, out, 1, the current offer is blocked by a pending producer.
- stall_cnt_o, out, CNT_W, consecutive hazard-stall cycles.

Function
REQ-003 Forwarded rs1 and rs2 values SHALL come from the lowest-index channel with fwd_valid=1 and a matching address; with no match, the register file data SHALL be used; index 0 SHALL never be forwarded.
REQ-004 Operand selection SHALL use the forwarded values r1 and r2:
- REG: r1, r2.
- IMM: r1, imm.
- FOUR_PC: XLEN'h4, pc.
- IMM_PC: pc, imm.
- CSR_REG: r1, csr.
- CSRIN_REG: ~r1, csr.
- CSR_IMM: csr, imm.
- Any other code: r1, r2.
REQ-005 Operand use SHALL be defined as: rs1 is used by REG, IMM, CSR_REG and CSRIN_REG; rs2 is used only by REG.
REQ-006 hazard_stall_o SHALL be 1 when in_valid_i=1 and a used operand's selected forwarding channel has fwd_pend=1; a pending channel of lower priority than a non-pending match SHALL be ignored.
REQ-007 in_ready_o SHALL equal (!out_valid_o || out_ready_i) && !hazard_stall_o && !flush_i.
REQ-008 On in_valid_i && in_ready_o, the outputs SHALL load at the next clk edge and out_valid_o SHALL be set (latency 1).
REQ-009 A simultaneous consume and accept SHALL replace the held pair with no bubble.
REQ-010 A consume without an accept SHALL clear out_valid_o; with out_valid_o=1 and out_ready_i=0, the held outputs SHALL remain stable.
REQ-011 flush_i SHALL clear out_valid_o at the next edge, SHALL take priority over accept and consume, and SHALL leave the operand registers unchanged.
REQ-012 stall_cnt_o SHALL increment each cycle that hazard_stall_o=1, saturate at 2^CNT_W-1, and clear on any cycle with hazard_stall_o=0 or flush_i=1.

Reset
REQ-013 rst=1 SHALL immediately and asynchronously force out_valid_o=0, alu_src1_o=0, alu_src2_o=0 and stall_cnt_o=0.
REQ-014 An operand pair held when reset asserts SHALL be lost; the first accept after release SHALL behave as from idle.

Structure
REQ-015 The select codes, `ALU_SRC_WIDTH and `CPU_WIDTH SHALL remain in the shared rooth_defines file; XLEN SHALL default to `CPU_WIDTH.
REQ-016 The forwarding lookup SHALL be a sub-module fwd_lookup (parameters N_FWD and XLEN), instantiated twice, with outputs data, hit and pend.

Verification
REQ-017 The bench SHALL cover these scenarios:
- REG, rs1=5, rs2=6; ch1 and ch2 both hit x5 with 0xAA and 0xBB -> src1=0xAA (ch1), src2=reg2 data, one cycle later.
- rs1=0, ch0 hits x0 with 0x1234 -> src1=reg1 data (0).
- IMM, rs1=7; ch0 hits x7 with fwd_pend=1 -> in_ready=0, hazard_stall=1, stall_cnt increments 1,2,3; pend drops -> accept, counter 0.
- out_valid=1, out_ready=0 for 4 cycles, new offers present -> outputs constant, in_ready=0.
- Accept and flush in the same cycle -> out_valid=0 next cycle, nothing accepted.
- FOUR_PC with pc=0x80000010 -> src1=4, src2=0x80000010; CSRIN_REG with r1=0xF0 -> src1=~0xF0; rst mid-hold -> outputs 0 immediately.
